// File: rtl/muldiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_ctrl_pkg
//  Description : Shared opcodes, FSM state encodings and helpers for the
//                HI/LO multiply/divide sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_ctrl_pkg;

    // Operand width of the integer datapath
    localparam int MD_XLEN = 32;

    // Request opcodes presented by the execute stage
    localparam logic [1:0] MD_OP_MUL  = 2'd0;
    localparam logic [1:0] MD_OP_DIV  = 2'd1;
    localparam logic [1:0] MD_OP_MTHI = 2'd2;
    localparam logic [1:0] MD_OP_MTLO = 2'd3;

    // Sequencer state encodings
    localparam logic [1:0] MD_S_IDLE = 2'd0;
    localparam logic [1:0] MD_S_MUL  = 2'd1;
    localparam logic [1:0] MD_S_DIV  = 2'd2;
    localparam logic [1:0] MD_S_FIX  = 2'd3;

    // Counter start values: multiply runs cnt 1..0, divide runs cnt 31..0
    localparam logic [4:0] MD_MUL_CNT_INIT = 5'd1;
    localparam logic [4:0] MD_DIV_CNT_INIT = 5'd31;

    // Magnitude of a value that is two's complement only when is_signed is set
    function automatic logic [MD_XLEN-1:0] md_mag(input logic [MD_XLEN-1:0] v,
                                                  input logic               is_signed);
        return (is_signed && v[MD_XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_ctrl_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : div_iter
//  Description : Unsigned 32-bit restoring divider datapath. One quotient bit
//                per step; operands must already be magnitudes.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_iter
    import muldiv_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               load,
    input  logic               step,
    input  logic [MD_XLEN-1:0] dividend,
    input  logic [MD_XLEN-1:0] divisor,
    output logic [MD_XLEN-1:0] quotient,
    output logic [MD_XLEN-1:0] remainder
);

    logic [MD_XLEN-1:0] r_rem;
    logic [MD_XLEN-1:0] r_quo;
    logic [MD_XLEN-1:0] r_div;

    logic [MD_XLEN:0]   w_shift;
    logic               w_fits;
    logic [MD_XLEN-1:0] w_diff;

    // Partial remainder shifted left by one with the next dividend bit brought
    // in from the top of the quotient register. When the divisor fits, the
    // true difference is below the divisor, so 32 bits hold it exactly.
    assign w_shift = {r_rem, r_quo[MD_XLEN-1]};
    assign w_fits  = (w_shift >= {1'b0, r_div});
    assign w_diff  = w_shift[MD_XLEN-1:0] - r_div;

    // Load operands, then shift one restoring-division step per enabled cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
        end else if (load) begin
            r_rem <= '0;
            r_quo <= dividend;
            r_div <= divisor;
        end else if (step) begin
            r_rem <= w_fits ? w_diff : w_shift[MD_XLEN-1:0];
            r_quo <= {r_quo[MD_XLEN-2:0], w_fits};
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_ctrl
//  Description : HI/LO owner and mul/div sequencer. 2-cycle multiply,
//                33-cycle restoring divide, zero-stall MTHI/MTLO, abortable
//                through cancel without disturbing HI/LO.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic               req_sign,
    input  logic [MD_XLEN-1:0] req_a,
    input  logic [MD_XLEN-1:0] req_b,
    input  logic               cancel,
    output logic               busy,
    output logic               done,
    output logic [MD_XLEN-1:0] hi,
    output logic [MD_XLEN-1:0] lo
);

    logic [1:0]         r_state;
    logic [4:0]         r_cnt;
    logic               r_sign;
    logic [MD_XLEN-1:0] r_a;
    logic [MD_XLEN-1:0] r_b;
    logic [63:0]        r_prod;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [MD_XLEN-1:0] r_hi;
    logic [MD_XLEN-1:0] r_lo;

    logic               w_idle;
    logic               w_accept;
    logic               w_mul_last;
    logic               w_commit_mul;
    logic               w_commit_div;
    logic               w_div_load;
    logic               w_div_step;
    logic [MD_XLEN-1:0] w_quo;
    logic [MD_XLEN-1:0] w_rem;
    logic [MD_XLEN-1:0] w_quo_fix;
    logic [MD_XLEN-1:0] w_rem_fix;
    logic signed [32:0] w_mul_a;
    logic signed [32:0] w_mul_b;
    logic signed [63:0] w_prod;

    assign w_idle     = (r_state == MD_S_IDLE);
    assign w_accept   = req_valid && w_idle && !cancel;
    assign w_mul_last = (r_state == MD_S_MUL) && (r_cnt == 5'd0);

    // Cancel always beats a commit landing in the same cycle
    assign w_commit_mul = w_mul_last && !cancel;
    assign w_commit_div = (r_state == MD_S_FIX) && !cancel;

    assign w_div_load = w_accept && (req_op == MD_OP_DIV);
    assign w_div_step = (r_state == MD_S_DIV) && !cancel;

    // 33x33 signed product: the extra top bit is the sign for signed ops and
    // zero for unsigned ops, so one signed multiplier serves both. The low
    // 64 bits of the widened product are the architectural result.
    assign w_mul_a = {r_sign & r_a[MD_XLEN-1], r_a};
    assign w_mul_b = {r_sign & r_b[MD_XLEN-1], r_b};
    assign w_prod  = 64'(w_mul_a) * 64'(w_mul_b);

    // Two's-complement fixups applied to the magnitude results in FIX
    assign w_quo_fix = r_neg_q ? (~w_quo + 1'b1) : w_quo;
    assign w_rem_fix = r_neg_r ? (~w_rem + 1'b1) : w_rem;

    div_iter u_div_iter (
        .clk       (clk),
        .resetn    (resetn),
        .load      (w_div_load),
        .step      (w_div_step),
        .dividend  (md_mag(req_a, req_sign)),
        .divisor   (md_mag(req_b, req_sign)),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    // Sequencer FSM and iteration counter
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= MD_S_IDLE;
            r_cnt   <= 5'd0;
        end else begin
            case (r_state)
                MD_S_IDLE: begin
                    if (w_accept && (req_op == MD_OP_MUL)) begin
                        r_state <= MD_S_MUL;
                        r_cnt   <= MD_MUL_CNT_INIT;
                    end else if (w_accept && (req_op == MD_OP_DIV)) begin
                        r_state <= MD_S_DIV;
                        r_cnt   <= MD_DIV_CNT_INIT;
                    end
                end
                MD_S_MUL: begin
                    if (cancel || (r_cnt == 5'd0)) begin
                        r_state <= MD_S_IDLE;
                        r_cnt   <= 5'd0;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                MD_S_DIV: begin
                    if (cancel) begin
                        r_state <= MD_S_IDLE;
                        r_cnt   <= 5'd0;
                    end else if (r_cnt == 5'd0) begin
                        r_state <= MD_S_FIX;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                default: begin
                    r_state <= MD_S_IDLE;
                    r_cnt   <= 5'd0;
                end
            endcase
        end
    end

    // Operand latches, sign-fixup flags and the registered product
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sign  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_prod  <= '0;
        end else begin
            if (w_accept && (req_op == MD_OP_MUL)) begin
                r_sign <= req_sign;
                r_a    <= req_a;
                r_b    <= req_b;
            end
            if (w_div_load) begin
                r_neg_q <= req_sign && (req_a[MD_XLEN-1] ^ req_b[MD_XLEN-1]);
                r_neg_r <= req_sign && req_a[MD_XLEN-1];
            end
            if ((r_state == MD_S_MUL) && (r_cnt == MD_MUL_CNT_INIT)) begin
                r_prod <= w_prod;
            end
        end
    end

    // Architectural HI/LO: written only by MTHI/MTLO accept or a mul/div commit
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_accept && (req_op == MD_OP_MTHI)) begin
            r_hi <= req_a;
        end else if (w_accept && (req_op == MD_OP_MTLO)) begin
            r_lo <= req_a;
        end else if (w_commit_mul) begin
            r_hi <= r_prod[63:32];
            r_lo <= r_prod[31:0];
        end else if (w_commit_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
        end
    end

    assign req_ready = w_idle;
    assign busy      = !w_idle;
    assign done      = w_commit_mul || w_commit_div;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_ctrl
//  Description : Self-checking bench for muldiv_ctrl with a behavioural
//                HI/LO reference model and randomized stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_sign;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks;
    int          n_errors;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    muldiv_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_sign  (req_sign),
        .req_a     (req_a),
        .req_b     (req_b),
        .cancel    (cancel),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Architectural result {hi, lo} computed with plain arithmetic
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic s,
                                               input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb;
        logic [31:0] ma, mb, q, r;
        if (op == MD_OP_MUL) begin
            xa = s ? {{32{a[31]}}, a} : {32'd0, a};
            xb = s ? {{32{b[31]}}, b} : {32'd0, b};
            return xa * xb;
        end
        ma = (s && a[31]) ? -a : a;
        mb = (s && b[31]) ? -b : b;
        if (mb == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (s && (a[31] != b[31])) q = -q;
        if (s && a[31])            r = -r;
        return {r, q};
    endfunction

    // Issue one request; optionally cancel at busy cycle cancel_cyc and/or keep
    // req_valid asserted while busy to confirm nothing is accepted
    task automatic run_op(input logic [1:0] op, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input int cancel_cyc, input bit hold);
        logic [63:0] res;
        int          lat;
        int          busy_cnt;
        bit          cancelled;
        res = ref_result(op, s, a, b);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_sign = s; req_a = a; req_b = b;
        #1 check("ready_idle", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (op == MD_OP_MTHI || op == MD_OP_MTLO) begin
            if (op == MD_OP_MTHI) m_hi = a; else m_lo = a;
            check("mt_hilo", {hi, lo}, {m_hi, m_lo});
            check("mt_busy", {63'd0, busy}, 64'd0);
            return;
        end
        lat       = (op == MD_OP_MUL) ? 2 : 33;
        busy_cnt  = 0;
        cancelled = 1'b0;
        for (int k = 1; k <= lat + 4; k++) begin
            if (!busy) break;
            busy_cnt++;
            if (hold) begin
                req_valid = 1'b1; req_op = MD_OP_MTHI; req_a = $urandom;
            end
            if (k == cancel_cyc) begin
                cancel = 1'b1; cancelled = 1'b1;
            end
            #1;
            check("ready_busy", {63'd0, req_ready}, 64'd0);
            check("done_pulse", {63'd0, done}, {63'd0, (k == lat) && !cancelled});
            check("hilo_stable", {hi, lo}, {m_hi, m_lo});
            @(posedge clk); #1;
            cancel = 1'b0; req_valid = 1'b0;
        end
        if (!cancelled) {m_hi, m_lo} = res;
        check("busy_cycles", 64'(busy_cnt), cancelled ? 64'(cancel_cyc) : 64'(lat));
        check("result", {hi, lo}, {m_hi, m_lo});
        check("done_idle", {63'd0, done}, 64'd0);
    endtask

    // Request presented together with cancel must be ignored
    task automatic cancel_with_valid(input logic [1:0] op);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_sign = 1'b0; req_a = $urandom; req_b = 32'd3;
        cancel = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; cancel = 1'b0;
        check("cv_hilo", {hi, lo}, {m_hi, m_lo});
        check("cv_busy", {63'd0, busy}, 64'd0);
        check("cv_done", {63'd0, done}, 64'd0);
    endtask

    // Synchronous reset asserted while a multiply is in flight
    task automatic reset_mid_mul();
        @(negedge clk);
        req_valid = 1'b1; req_op = MD_OP_MUL; req_sign = 1'b0;
        req_a = 32'h1234_5678; req_b = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        resetn    = 1'b0;
        @(posedge clk); #1;
        m_hi = 32'd0; m_lo = 32'd0;
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ready", {63'd0, req_ready}, 64'd1);
        resetn = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        m_hi      = 32'd0;
        m_lo      = 32'd0;
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_op    = MD_OP_MUL;
        req_sign  = 1'b0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        cancel    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hilo",  {hi, lo}, 64'd0);
        check("reset_busy",  {63'd0, busy}, 64'd0);
        check("reset_done",  {63'd0, done}, 64'd0);
        check("reset_ready", {63'd0, req_ready}, 64'd1);
        resetn = 1'b1;

        // Directed corner cases
        run_op(MD_OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(MD_OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
        run_op(MD_OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_op(MD_OP_DIV, 1'b0, 32'd100, 32'd7, 0, 1'b1);
        run_op(MD_OP_DIV, 1'b0, 32'h1234_5678, 32'd0, 0, 1'b0);
        run_op(MD_OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(MD_OP_DIV, 1'b1, 32'hFFFF_FF00, 32'd0, 0, 1'b0);
        run_op(MD_OP_MTHI, 1'b0, 32'hDEAD_BEEF, 32'd0, 0, 1'b0);
        run_op(MD_OP_MTLO, 1'b0, 32'h0000_0001, 32'd0, 0, 1'b0);
        run_op(MD_OP_DIV, 1'b0, 32'hCAFE_0000, 32'd5, 10, 1'b0);
        run_op(MD_OP_DIV, 1'b1, 32'h7654_3210, 32'hFFFF_FF01, 33, 1'b0);
        run_op(MD_OP_MUL, 1'b0, 32'h0001_0000, 32'h0001_0000, 2, 1'b0);
        cancel_with_valid(MD_OP_MTHI);
        cancel_with_valid(MD_OP_DIV);
        run_op(MD_OP_MUL, 1'b1, 32'h8000_0000, 32'h8000_0000, 0, 1'b1);
        reset_mid_mul();
        run_op(MD_OP_MUL, 1'b0, 32'd3, 32'd5, 0, 1'b0);

        // Randomized mix with biased corner operands
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic        s;
            logic [31:0] a, b;
            int          cc;
            op = 2'($urandom_range(0, 3));
            s  = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 16));
                default: ;
            endcase
            cc = ($urandom_range(0, 5) == 0) ?
                 int'($urandom_range(1, (op == MD_OP_MUL) ? 2 : 33)) : 0;
            run_op(op, s, a, b, cc, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
